mem_req_rr_arbiter: RTL
=======================

// Module: mem_req_rr_arbiter
// PURPOSE
//  Upstream stage of the requestor/memory mux: merges N requestor request streams into one
//  registered memory request port by round-robin arbitration. Tags each request with its
//  requestor index, tracks outstanding requests against a credit limit and steers returning
//  responses back to the issuing requestor as a one-hot valid.
// PARAMETERS
//  N_REQ     4   number of requestors (2..8)
//  DATA_W    32  request payload width
//  ID_W      2   requestor tag width, = clog2(N_REQ)
//  MAX_OUT   4   max in-flight requests not yet answered (1..15)
// PORTS
//  clk            in   1             rising-edge clock
//  reset_n        in   1             asynchronous, active-low reset
//  req_valid      in   N_REQ         requestor i has a request
//  req_ready      out  N_REQ         requestor i request accepted this cycle
//  req_bits       in   N_REQ*DATA_W  payload; slice i = [i*DATA_W +: DATA_W]
//  mem_valid      out  1             output register holds a request
//  mem_ready      in   1             memory accepts mem_* this cycle
//  mem_bits       out  DATA_W        registered payload
//  mem_id         out  ID_W          registered requestor index
//  mem_resp_valid in   1             memory returns a response
//  mem_resp_id    in   ID_W          tag of returned response
//  resp_valid     out  N_REQ         one-hot response strobe to requestors
//  outstanding    out  clog2(MAX_OUT+1) in-flight count (debug/verification)
// BEHAVIOUR
//  - Reset (reset_n low, async): mem_valid=0, mem_bits=0, mem_id=0, outstanding=0,
//    last_grant=N_REQ-1 (requestor 0 highest priority first). req_ready, resp_valid are
//    combinational and therefore 0 while out_reg full/blocked and no response.
//  - Accept condition: load = (~mem_valid | mem_ready) & credit_ok & |req_valid.
//    credit_ok = (outstanding + mem_valid_reg_counted) < MAX_OUT, where a request counts
//    as outstanding from the cycle it is loaded into the output register.
//  - Grant: first requestor with req_valid set, scanning from last_grant+1 upward, wrapping
//    modulo N_REQ. req_ready[g]=load for that g only; all other req_ready=0. At most one
//    bit of req_ready set. req_ready independent of req_valid of non-granted lanes only.
//  - On load: mem_bits<=req_bits[g], mem_id<=g, mem_valid<=1, last_grant<=g. Latency
//    request-accept -> mem_valid = 1 cycle. Throughput 1 request/cycle when mem_ready=1.
//  - mem_valid & ~mem_ready: register holds; mem_bits/mem_id stable until accepted.
//  - mem_valid & mem_ready & ~load: mem_valid<=0 next cycle.
//  - outstanding: +1 on load, -1 on mem_resp_valid; both same cycle -> unchanged.
//    credit_ok uses the pre-update count plus mem_resp_valid: a response in the same cycle
//    frees a credit (outstanding==MAX_OUT & mem_resp_valid -> load allowed).
//  - resp_valid[i] = mem_resp_valid & (mem_resp_id==i); combinational, zero latency.
//    mem_resp_valid with outstanding==0 is a protocol error: count saturates at 0
//    (no underflow); assertion fires in simulation.
//  - mem_resp_id >= N_REQ: resp_valid all 0, counter still decrements.
//  - No requestor valid: last_grant unchanged, no load.
//  - Reset asserted mid-transfer: pending output request and all credits dropped;
//    system reset also clears memory side, so no responses expected afterwards.
// TESTING
//  1 Reset: hold reset_n=0 -> mem_valid=0, outstanding=0, req_ready=0000; release, req_valid=0001
//    bits=0xA5 -> next cycle mem_valid=1, mem_bits=0xA5, mem_id=0.
//  2 Fairness: all 4 req_valid=1 continuously, mem_ready=1, responses returned 1 cycle after
//    accept -> grant order 0,1,2,3,0,1... one per cycle, mem_id sequence matches.
//  3 Backpressure: mem_valid=1, mem_ready=0 for 5 cycles with new req_valid=1111 -> req_ready=0000,
//    mem_bits/mem_id unchanged; mem_ready=1 -> next grantee is last_grant+1.
//  4 Credit limit: MAX_OUT=4, no responses, req_valid=1111 -> exactly 4 loads then req_ready=0;
//    mem_resp_valid=1 with mem_resp_id=2 same cycle as pending request -> load occurs, count stays 4.
//  5 Response steering: mem_resp_valid=1, mem_resp_id=3 -> resp_valid=1000 same cycle; id=0 ->
//    0001; outstanding decrements by 1 each.
//  6 Wrap/sparse: last_grant=3, req_valid=0101 -> grant 0; then grant 2; async reset mid-stall ->
//    mem_valid drops immediately, outstanding=0.

Source files
------------

// File: rtl/mem_req_rr_arbiter.sv
// Round-robin merge of N_REQ request streams into one registered memory request port,
// with credit-limited issue and one-hot steering of returning responses.
module mem_req_rr_arbiter #(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ID_W    = 2,
   parameter int unsigned MAX_OUT = 4,
   localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1)
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_bits,
   output logic                    mem_valid,
   input  logic                    mem_ready,
   output logic [DATA_W-1:0]       mem_bits,
   output logic [ID_W-1:0]         mem_id,
   input  logic                    mem_resp_valid,
   input  logic [ID_W-1:0]         mem_resp_id,
   output logic [N_REQ-1:0]        resp_valid,
   output logic [CNT_W-1:0]        outstanding
);

   logic                 mem_valid_q, mem_valid_d;
   logic [DATA_W-1:0]    mem_bits_q, mem_bits_d;
   logic [ID_W-1:0]      mem_id_q, mem_id_d;
   logic [ID_W-1:0]      last_grant_q, last_grant_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   logic [ID_W:0]        scan_start;
   logic [2*N_REQ-1:0]   req_dbl;
   logic [N_REQ-1:0]     req_rot;
   logic [ID_W-1:0]      rot_off;
   logic [ID_W:0]        grant_sum;
   logic [ID_W-1:0]      grant;
   logic                 any_req;
   logic                 slot_free;
   logic                 credit_ok;
   logic                 load;
   logic                 resp_dec;

   // Rotate the request vector so bit 0 is the lane just after the last grant; the lowest set
   // bit of the rotated vector is then the round-robin winner.
   always_comb begin
      scan_start = {1'b0, last_grant_q} + 1'b1;
      req_dbl    = {req_valid, req_valid} >> scan_start;
      req_rot    = req_dbl[N_REQ-1:0];
      rot_off    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            rot_off = ID_W'(i);
         end
      end
      grant_sum = scan_start + {1'b0, rot_off};
      if (grant_sum >= (ID_W + 1)'(N_REQ)) begin
         grant_sum = grant_sum - (ID_W + 1)'(N_REQ);
      end
      grant = grant_sum[ID_W-1:0];
   end

   // A same-cycle response frees a credit, so a full counter still admits a load.
   always_comb begin
      any_req   = |req_valid;
      slot_free = ~mem_valid_q | mem_ready;
      credit_ok = (cnt_q < CNT_W'(MAX_OUT)) | mem_resp_valid;
      load      = slot_free & credit_ok & any_req;
   end

   always_comb begin
      req_ready = '0;
      if (load) begin
         req_ready[grant] = 1'b1;
      end
   end

   always_comb begin
      resp_valid = '0;
      for (int i = 0; i < N_REQ; i++) begin
         resp_valid[i] = mem_resp_valid & (mem_resp_id == ID_W'(i));
      end
   end

   always_comb begin
      mem_valid_d  = mem_valid_q;
      mem_bits_d   = mem_bits_q;
      mem_id_d     = mem_id_q;
      last_grant_d = last_grant_q;
      if (load) begin
         mem_valid_d  = 1'b1;
         mem_bits_d   = req_bits[grant*DATA_W +: DATA_W];
         mem_id_d     = grant;
         last_grant_d = grant;
      end else if (mem_ready) begin
         mem_valid_d = 1'b0;
      end
   end

   // A response with nothing in flight is ignored rather than wrapping the counter.
   always_comb begin
      resp_dec = mem_resp_valid & (cnt_q != '0);
      cnt_d    = cnt_q;
      unique case ({load, resp_dec})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_valid_q  <= 1'b0;
         mem_bits_q   <= '0;
         mem_id_q     <= '0;
         last_grant_q <= ID_W'(N_REQ - 1);
         cnt_q        <= '0;
      end else begin
         mem_valid_q  <= mem_valid_d;
         mem_bits_q   <= mem_bits_d;
         mem_id_q     <= mem_id_d;
         last_grant_q <= last_grant_d;
         cnt_q        <= cnt_d;
      end
   end

   assign mem_valid   = mem_valid_q;
   assign mem_bits    = mem_bits_q;
   assign mem_id      = mem_id_q;
   assign outstanding = cnt_q;

   a_no_resp_underflow: assert property (@(posedge clk) disable iff (!reset_n)
      mem_resp_valid |-> (cnt_q != '0));

endmodule
